// File: rtl/stage_m_ws.sv
// Memory pipeline stage: E->M register, byte-lane data RAM, load extension,
// misalignment detection and a programmable wait-state stall.
module stage_m_ws #(
    parameter int XLEN  = 32,
    parameter int RW    = 5,
    parameter int DEPTH = 1024,
    parameter int LAT   = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            arm,
    input  logic            FlushM,
    input  logic [XLEN-1:0] ALUResultE,
    input  logic [XLEN-1:0] WriteDataE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [RW-1:0]   RdE,
    input  logic            PCSrcE,
    input  logic            RegWriteE,
    input  logic [1:0]      ResultSrcE,
    input  logic            MemWriteE,
    input  logic [1:0]      SizeE,
    input  logic            UnsignedE,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [RW-1:0]   RdM,
    output logic            PCSrcM,
    output logic            RegWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [XLEN-1:0] ReadDataW,
    output logic            StallM,
    output logic            MisalignM
);

    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned OW = $clog2(NB);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [XLEN-1:0] alu_result_q, alu_result_d;
    logic [XLEN-1:0] write_data_q, write_data_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
    logic [RW-1:0]   rd_q, rd_d;
    logic            pc_src_q, pc_src_d;
    logic            reg_write_q, reg_write_d;
    logic [1:0]      result_src_q, result_src_d;
    logic            mem_write_q, mem_write_d;
    logic [1:0]      size_q, size_d;
    logic            unsigned_q, unsigned_d;
    logic [XLEN-1:0] read_data_q, read_data_d;
    logic [3:0]      cnt_q, cnt_d;

    logic [XLEN-1:0] ram [DEPTH];
    logic [AW-1:0]   word_idx;
    logic [OW-1:0]   offset;
    logic [XLEN-1:0] ram_rword, ram_wdata, raw, load_ext;
    logic [XLEN-1:0] lane_mask, keep_mask;
    logic            is_load, is_mem, misalign, memop, stall, sign_bit, ram_we;
    int unsigned     offs, nbytes, nbits;

    assign word_idx  = alu_result_q[OW +: AW];
    assign offset    = alu_result_q[OW-1:0];
    assign ram_rword = ram[word_idx];

    always_comb begin
        offs     = 32'(offset);
        nbytes   = 32'd1 << size_q;
        nbits    = nbytes * 32'd8;
        is_load  = (result_src_q == 2'b01);
        is_mem   = is_load || mem_write_q;
        misalign = is_mem && ((((offs & (nbytes - 32'd1)) != 32'd0)) ||
                              (XLEN == 32 && size_q == 2'b11));
        memop    = is_mem && !misalign;
        stall    = memop && (cnt_q != 4'(LAT));
        ram_we   = memop && !stall && mem_write_q;

        lane_mask = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (i >= offs && i < offs + nbytes) begin
                lane_mask = lane_mask | (XLEN'(8'hFF) << (8 * i));
            end
        end
        ram_wdata = (ram_rword & ~lane_mask) |
                    ((write_data_q << {offset, 3'b000}) & lane_mask);

        // Shift the addressed bytes down, then mask and sign-fill above the access width.
        raw       = ram_rword >> {offset, 3'b000};
        keep_mask = (nbits >= XLEN) ? '1 : ((XLEN'(1) << nbits) - XLEN'(1));
        sign_bit  = |(raw & (XLEN'(1) << (nbits - 32'd1)));
        load_ext  = raw & keep_mask;
        if (!unsigned_q && !arm && sign_bit) begin
            load_ext = load_ext | ~keep_mask;
        end
    end

    always_comb begin
        alu_result_d = alu_result_q;
        write_data_d = write_data_q;
        pc_plus4_d   = pc_plus4_q;
        rd_d         = rd_q;
        pc_src_d     = pc_src_q;
        reg_write_d  = reg_write_q;
        result_src_d = result_src_q;
        mem_write_d  = mem_write_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        read_data_d  = read_data_q;
        cnt_d        = '0;
        if (stall) begin
            cnt_d = cnt_q + 4'd1;
        end else if (FlushM) begin
            alu_result_d = '0;
            write_data_d = '0;
            pc_plus4_d   = '0;
            rd_d         = '0;
            pc_src_d     = 1'b0;
            reg_write_d  = 1'b0;
            result_src_d = '0;
            mem_write_d  = 1'b0;
            size_d       = '0;
            unsigned_d   = 1'b0;
        end else begin
            alu_result_d = ALUResultE;
            write_data_d = WriteDataE;
            pc_plus4_d   = PCPlus4E;
            rd_d         = RdE;
            pc_src_d     = PCSrcE;
            reg_write_d  = RegWriteE;
            result_src_d = ResultSrcE;
            mem_write_d  = MemWriteE;
            size_d       = SizeE;
            unsigned_d   = UnsignedE;
        end
        if (!stall && is_load) begin
            read_data_d = misalign ? '0 : load_ext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_result_q <= '0;
            write_data_q <= '0;
            pc_plus4_q   <= '0;
            rd_q         <= '0;
            pc_src_q     <= 1'b0;
            reg_write_q  <= 1'b0;
            result_src_q <= '0;
            mem_write_q  <= 1'b0;
            size_q       <= '0;
            unsigned_q   <= 1'b0;
            read_data_q  <= '0;
            cnt_q        <= '0;
        end else begin
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            pc_plus4_q   <= pc_plus4_d;
            rd_q         <= rd_d;
            pc_src_q     <= pc_src_d;
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            mem_write_q  <= mem_write_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            read_data_q  <= read_data_d;
            cnt_q        <= cnt_d;
        end
    end

    // No reset on the array; reset clears the M register, so ram_we is already low.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[word_idx] <= ram_wdata;
        end
    end

    assign ALUResultM = alu_result_q;
    assign PCPlus4M   = pc_plus4_q;
    assign RdM        = rd_q;
    assign PCSrcM     = pc_src_q;
    assign RegWriteM  = reg_write_q;
    assign ResultSrcM = result_src_q;
    assign ReadDataW  = read_data_q;
    assign StallM     = stall;
    assign MisalignM  = misalign;

endmodule

// File: tb/tb_stage_m_ws.sv
// Directed bench for stage_m_ws: three instances (32-bit LAT=0, 32-bit LAT=3,
// 64-bit DEPTH=16); only one is out of reset at a time, all share the E inputs.
module tb_stage_m_ws;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, rst_c;
    logic        arm_e, flush_e, pcsrc_e, regw_e, memw_e, uns_e;
    logic [63:0] alu_e, wd_e, pc4_e;
    logic [4:0]  rd_e;
    logic [1:0]  rsrc_e, size_e;

    logic [31:0] a_alu, a_pc4, a_rdw;
    logic [4:0]  a_rd;
    logic [1:0]  a_rsrc;
    logic        a_pcsrc, a_regw, a_stall, a_mis;
    logic [31:0] b_alu, b_pc4, b_rdw;
    logic [4:0]  b_rd;
    logic [1:0]  b_rsrc;
    logic        b_pcsrc, b_regw, b_stall, b_mis;
    logic [63:0] c_alu, c_pc4, c_rdw;
    logic [4:0]  c_rd;
    logic [1:0]  c_rsrc;
    logic        c_pcsrc, c_regw, c_stall, c_mis;

    stage_m_ws #(.XLEN(32), .RW(5), .DEPTH(1024), .LAT(0)) dut_a (
        .clk(clk), .rst(rst_a), .arm(arm_e), .FlushM(flush_e),
        .ALUResultE(alu_e[31:0]), .WriteDataE(wd_e[31:0]), .PCPlus4E(pc4_e[31:0]),
        .RdE(rd_e), .PCSrcE(pcsrc_e), .RegWriteE(regw_e), .ResultSrcE(rsrc_e),
        .MemWriteE(memw_e), .SizeE(size_e), .UnsignedE(uns_e),
        .ALUResultM(a_alu), .PCPlus4M(a_pc4), .RdM(a_rd), .PCSrcM(a_pcsrc),
        .RegWriteM(a_regw), .ResultSrcM(a_rsrc), .ReadDataW(a_rdw),
        .StallM(a_stall), .MisalignM(a_mis)
    );

    stage_m_ws #(.XLEN(32), .RW(5), .DEPTH(1024), .LAT(3)) dut_b (
        .clk(clk), .rst(rst_b), .arm(arm_e), .FlushM(flush_e),
        .ALUResultE(alu_e[31:0]), .WriteDataE(wd_e[31:0]), .PCPlus4E(pc4_e[31:0]),
        .RdE(rd_e), .PCSrcE(pcsrc_e), .RegWriteE(regw_e), .ResultSrcE(rsrc_e),
        .MemWriteE(memw_e), .SizeE(size_e), .UnsignedE(uns_e),
        .ALUResultM(b_alu), .PCPlus4M(b_pc4), .RdM(b_rd), .PCSrcM(b_pcsrc),
        .RegWriteM(b_regw), .ResultSrcM(b_rsrc), .ReadDataW(b_rdw),
        .StallM(b_stall), .MisalignM(b_mis)
    );

    stage_m_ws #(.XLEN(64), .RW(5), .DEPTH(16), .LAT(0)) dut_c (
        .clk(clk), .rst(rst_c), .arm(arm_e), .FlushM(flush_e),
        .ALUResultE(alu_e), .WriteDataE(wd_e), .PCPlus4E(pc4_e),
        .RdE(rd_e), .PCSrcE(pcsrc_e), .RegWriteE(regw_e), .ResultSrcE(rsrc_e),
        .MemWriteE(memw_e), .SizeE(size_e), .UnsignedE(uns_e),
        .ALUResultM(c_alu), .PCPlus4M(c_pc4), .RdM(c_rd), .PCSrcM(c_pcsrc),
        .RegWriteM(c_regw), .ResultSrcM(c_rsrc), .ReadDataW(c_rdw),
        .StallM(c_stall), .MisalignM(c_mis)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        regw_e = 1'b0; rsrc_e = 2'b00; memw_e = 1'b0; pcsrc_e = 1'b0;
        size_e = 2'b00; uns_e = 1'b0; alu_e = '0; wd_e = '0; pc4_e = '0; rd_e = '0;
    endtask

    task automatic st(input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz);
        idle();
        memw_e = 1'b1; alu_e = a; wd_e = d; size_e = sz;
    endtask

    task automatic ld(input logic [63:0] a, input logic [1:0] sz, input logic u, input logic [4:0] rd);
        idle();
        regw_e = 1'b1; rsrc_e = 2'b01; alu_e = a; size_e = sz; uns_e = u; rd_e = rd;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        arm_e = 1'b0; flush_e = 1'b0;
        idle();
        #2;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        tick(); tick();
        chk("rst_a_rdw", a_rdw, 0);
        chk("rst_a_alu", a_alu, 0);
        chk("rst_a_regw", a_regw, 0);
        chk("rst_b_stall", b_stall, 0);
        chk("rst_c_rdw", c_rdw, 0);
        rst_a = 1'b1;

        // word store then load, LAT=0
        st(64'h10, 64'hDEADBEEF, 2'b10); tick();
        chk("p1_st_stall", a_stall, 0);
        chk("p1_st_mis", a_mis, 0);
        ld(64'h10, 2'b10, 1'b0, 5'd3); pc4_e = 64'h1004; pcsrc_e = 1'b1; tick();
        chk("p1_ld_stall", a_stall, 0);
        chk("p1_ld_rsrc", a_rsrc, 2'b01);
        chk("p1_ld_rd", a_rd, 3);
        chk("p1_ld_pc4", a_pc4, 64'h1004);
        chk("p1_ld_pcsrc", a_pcsrc, 1);
        chk("p1_ld_alu", a_alu, 64'h10);
        idle(); tick();
        chk("p1_ld_data", a_rdw, 64'hDEADBEEF);

        // byte store, signed/ARM/word/half loads
        st(64'h13, 64'h12345680, 2'b00); tick();
        ld(64'h13, 2'b00, 1'b0, 5'd4); tick();
        ld(64'h13, 2'b00, 1'b0, 5'd4); tick();
        chk("p2_lb_rv", a_rdw, 64'hFFFFFF80);
        arm_e = 1'b1; ld(64'h10, 2'b10, 1'b0, 5'd5); tick();
        chk("p2_lb_arm", a_rdw, 64'h00000080);
        arm_e = 1'b0; ld(64'h12, 2'b01, 1'b0, 5'd6); tick();
        chk("p2_lw", a_rdw, 64'h80ADBEEF);
        ld(64'h12, 2'b01, 1'b1, 5'd6); tick();
        chk("p2_lh", a_rdw, 64'hFFFF80AD);
        idle(); tick();
        chk("p2_lhu", a_rdw, 64'h000080AD);

        // flush inserts a bubble
        ld(64'h10, 2'b10, 1'b0, 5'd7); flush_e = 1'b1; tick();
        chk("fl_regw", a_regw, 0);
        chk("fl_alu", a_alu, 0);
        chk("fl_rdw_hold", a_rdw, 64'h000080AD);
        flush_e = 1'b0;

        // misaligned half store/load and double on XLEN=32
        st(64'h11, 64'h0000AAAA, 2'b01); tick();
        chk("p4_st_mis", a_mis, 1);
        chk("p4_st_stall", a_stall, 0);
        ld(64'h11, 2'b01, 1'b0, 5'd8); tick();
        chk("p4_ld_mis", a_mis, 1);
        ld(64'h10, 2'b11, 1'b0, 5'd8); tick();
        chk("p4_ld_zero", a_rdw, 0);
        chk("p4_dbl_mis", a_mis, 1);
        ld(64'h10, 2'b10, 1'b0, 5'd8); tick();
        idle(); tick();
        chk("p4_ram_kept", a_rdw, 64'h80ADBEEF);
        rst_a = 1'b0; #1;
        chk("p4_async_rst", a_rdw, 0);

        // LAT=3 stall behaviour
        rst_b = 1'b1;
        st(64'h20, 64'hCAFEF00D, 2'b10); tick();
        chk("p3_st_stall0", b_stall, 1);
        ld(64'h20, 2'b10, 1'b0, 5'd7); tick();
        chk("p3_st_stall1", b_stall, 1);
        tick();
        chk("p3_st_stall2", b_stall, 1);
        tick();
        chk("p3_st_done", b_stall, 0);
        chk("p3_st_rsrc", b_rsrc, 0);
        tick();
        chk("p3_ld_stall1", b_stall, 1);
        chk("p3_ld_rd", b_rd, 7);
        st(64'h44, 64'h55, 2'b10); rd_e = 5'd9; flush_e = 1'b1; tick();
        chk("p3_hold_rd", b_rd, 7);
        chk("p3_hold_alu", b_alu, 64'h20);
        chk("p3_ld_stall2", b_stall, 1);
        flush_e = 1'b0; idle(); tick();
        chk("p3_ld_stall3", b_stall, 1);
        chk("p3_rdw_pending", b_rdw, 0);
        tick();
        chk("p3_stall_end", b_stall, 0);
        tick();
        chk("p3_rdw", b_rdw, 64'hCAFEF00D);
        chk("p3_rd_after", b_rd, 0);

        // reset mid-stall aborts the store
        st(64'h20, 64'h11112222, 2'b10); tick();
        chk("p5_stall", b_stall, 1);
        tick();
        rst_b = 1'b0; #1;
        chk("p5_rst_rdw", b_rdw, 0);
        chk("p5_rst_stall", b_stall, 0);
        chk("p5_rst_alu", b_alu, 0);
        idle(); tick();
        rst_b = 1'b1;
        ld(64'h20, 2'b10, 1'b0, 5'd2); tick();
        idle(); tick(); tick(); tick();
        chk("p5_ld_stall_end", b_stall, 0);
        tick();
        chk("p5_old_data", b_rdw, 64'hCAFEF00D);
        rst_b = 1'b0;

        // XLEN=64, DEPTH=16 with address wrap
        rst_c = 1'b1;
        st(64'h80, 64'h0123456789ABCDEF, 2'b11); tick();
        chk("p6_st_mis", c_mis, 0);
        chk("p6_st_stall", c_stall, 0);
        ld(64'h00, 2'b11, 1'b0, 5'd1); tick();
        idle(); tick();
        chk("p6_ld_dbl", c_rdw, 64'h0123456789ABCDEF);
        ld(64'h04, 2'b10, 1'b0, 5'd1); tick();
        idle(); tick();
        chk("p6_lw4", c_rdw, 64'h0000000001234567);
        ld(64'h00, 2'b10, 1'b0, 5'd1); tick();
        idle(); tick();
        chk("p6_lw0", c_rdw, 64'hFFFFFFFF89ABCDEF);
        ld(64'h04, 2'b11, 1'b0, 5'd1); tick();
        chk("p6_dbl_mis", c_mis, 1);
        idle(); tick();
        chk("p6_dbl_zero", c_rdw, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stage_m_ws.md
Name: stage_m_ws

Overview:
- Parametrised memory pipeline stage for the combined ARM/RV core.
- Holds the E->M pipeline register and an internal byte-lane data RAM.
- Supports byte/half/word/(double) accesses, sign/zero load extension, misalignment detection, and a configurable number of memory wait states.
- While a memory access is in progress it stalls upstream via StallM.
- Sits between stage_e and the writeback stage; ReadDataW feeds writeback directly.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64; byte lanes = XLEN/8.
- RW, 5, destination register index width.
- DEPTH, 1024, RAM depth in XLEN-wide words; power of two.
- LAT, 0, memory wait states per load/store; 0..15.

Ports:
- clk in 1: clock, rising edge.
- rst in 1: asynchronous, active-low reset.
- arm in 1: 1 = ARM mode (loads always zero-extend), 0 = RV mode.
- FlushM in 1: insert a bubble into M instead of capturing E.
- ALUResultE in XLEN: byte address / ALU result.
- WriteDataE in XLEN: store data, LSB-aligned.
- PCPlus4E in XLEN: RV link value.
- RdE in RW: destination register.
- PCSrcE in 1: ARM branch-taken flag.
- RegWriteE in 1: register write enable.
- ResultSrcE in 2: result select; 01 = load.
- MemWriteE in 1: store.
- SizeE in 2: access size; 00 = byte, 01 = half, 10 = word, 11 = double (XLEN=64 only).
- UnsignedE in 1: zero-extend load (RV LBU/LHU/LWU).
- ALUResultM out XLEN: registered ALU result.
- PCPlus4M out XLEN: registered PCPlus4E.
- RdM out RW: registered RdE.
- PCSrcM out 1: registered PCSrcE.
- RegWriteM out 1: registered RegWriteE.
- ResultSrcM out 2: registered ResultSrcE.
- ReadDataW out XLEN: extended load data.
- StallM out 1: hold upstream stages and this stage's register.
- MisalignM out 1: current M access is misaligned.

Behaviour:
- Reset (rst=0, asynchronous): all M registers 0, ReadDataW=0, wait counter=0, StallM=0, MisalignM=0.
  - RAM contents are not reset.
  - Reset during a stall aborts the access; a pending store is not written.
- Pipeline register update on each clk edge:
  - If StallM=1: hold.
  - Else if FlushM=1: load a bubble (RegWrite, MemWrite, PCSrc, ResultSrc, Size, Unsigned = 0; data fields 0).
  - Else: capture all E inputs.
- FlushM is ignored while StallM=1.
- memop = (ResultSrcM==01 or MemWriteM) and not MisalignM.
- Wait counter cnt (4 bits):
  - Cleared to 0 whenever the M register captures or flushes.
  - Increments on each edge while StallM=1.
- StallM = memop and (cnt != LAT), combinational.
  - A memop occupies M for exactly LAT+1 cycles.
  - With LAT=0, StallM is never asserted.
- The access commits at the first edge with memop=1 and StallM=0.
- Word index = ALUResultM[log2(XLEN/8) +: log2(DEPTH)]; higher address bits are ignored (the address wraps modulo DEPTH).
- Byte offset = low log2(XLEN/8) address bits.
- MisalignM = (ResultSrcM==01 or MemWriteM) and the offset is not a multiple of the access size.
  - Size 11 with XLEN=32 also counts as misaligned.
  - A misaligned access does not stall, does not write, and returns 0 on a load.
- Store:
  - Write only the lanes offset .. offset+size-1.
  - Data comes from WriteDataM low bytes, shifted to the offset.
  - Other lanes are unchanged.
- Load:
  - Select bytes at the offset.
  - Sign-extend to XLEN, unless UnsignedM=1, arm=1, or the size equals XLEN.
  - Register the result into ReadDataW at the commit edge.
- ReadDataW holds its value on all other edges; for a misaligned load it loads 0 at the next edge.
- A store and a load are never in M together.
- A load issued in the cycle after a store to the same address returns the new data, with no bypass hazard.

Test Plan:
1. LAT=0, XLEN=32: store word 0xDEADBEEF to 0x10, then load word 0x10 → StallM never high; ReadDataW=0xDEADBEEF one cycle after the load is in M.
2. Store byte 0x80 to 0x13; load byte 0x13 with arm=0, Unsigned=0 → 0xFFFFFF80; same load with arm=1 → 0x00000080; then load word 0x10 → 0x80ADBEEF.
3. LAT=3: load with ResultSrcE=01 → StallM high for exactly 3 cycles; M outputs held; ReadDataW valid at the 4th edge; FlushM pulsed mid-stall is ignored.
4. Half store to 0x11 → MisalignM=1, no stall, RAM unchanged; half load from 0x11 → ReadDataW=0.
5. LAT=3: store issued, then rst pulled low after 1 stall cycle → outputs 0, StallM=0; subsequent load of that address returns the old data.
6. XLEN=64, DEPTH=16: store double 0x0123456789ABCDEF at 0x80 (wraps to index 0); load double at 0x00 → 0x0123456789ABCDEF; load word 0x04 signed → 0x0000000001234567.
